// File: rtl/msu_audio_sample_fifo.sv
// MSU audio sample FIFO: drops the PCM header and skipped words, buffers the rest in a
// 2048-word FIFO, and plays stereo L/R pairs at the sample rate from a drift-free accumulator.
module msu_audio_sample_fifo #(
  parameter int CLK_HZ       = 21477272,
  parameter int SAMPLE_RATE  = 44100,
  parameter int ADDR_W       = 11,
  parameter int HEADER_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              audio_play,
  input  logic              sd_ack_1,
  input  logic              sd_buff_wr,
  input  logic [15:0]       sd_buff_dout,
  input  logic              ignore_sd_buffer_out,
  output logic [ADDR_W:0]   audio_fifo_usedw,
  output logic [15:0]       audio_l,
  output logic [15:0]       audio_r,
  output logic              sample_strobe,
  output logic              underflow,
  output logic              overflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_PAIR = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [31:0]     RATE_INC = 32'(SAMPLE_RATE);
  localparam logic [31:0]     CLK_LIM  = 32'(CLK_HZ);
  localparam logic [15:0]     HDR_INIT = 16'(HEADER_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RD_L, S_RD_R, S_CAP_R} state_t;

  logic [15:0]       r_mem [DEPTH];
  logic [15:0]       r_rd_data;
  logic [15:0]       r_l_hold;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_hdr_cnt;
  logic [31:0]       r_acc;
  state_t            r_state;
  state_t            w_next_state;

  logic        w_cand;
  logic        w_hdr_drop;
  logic        w_full;
  logic        w_write;
  logic        w_ovf;
  logic        w_pop;
  logic        w_underflow;
  logic        w_mute;
  logic        w_present;
  logic        w_tick;
  logic [31:0] w_acc_sum;

  assign w_cand     = sd_ack_1 && sd_buff_wr && !ignore_sd_buffer_out;
  assign w_hdr_drop = w_cand && (r_hdr_cnt != 16'd0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_write    = w_cand && !w_hdr_drop && !w_full && !flush;
  assign w_ovf      = w_cand && !w_hdr_drop && w_full;
  assign w_acc_sum  = r_acc + RATE_INC;
  assign w_tick     = (w_acc_sum >= CLK_LIM);

  assign audio_fifo_usedw = r_count;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_underflow  = 1'b0;
    w_mute       = 1'b0;
    w_present    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          if (!audio_play)
            w_mute = 1'b1;
          else if (r_count >= CNT_PAIR)
            w_next_state = S_RD_L;
          else
            w_underflow = 1'b1;
        end
      end
      S_RD_L: begin
        w_pop        = 1'b1;
        w_next_state = S_RD_R;
      end
      S_RD_R: begin
        w_pop        = 1'b1;
        w_next_state = S_CAP_R;
      end
      S_CAP_R: begin
        w_present    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else if (flush)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Storage has no reset so it maps onto block RAM; read data lags the pop by one cycle.
  always_ff @(posedge clk) begin
    if (w_write)
      r_mem[r_wr_ptr] <= sd_buff_dout;
    if (w_pop && !flush)
      r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_hdr_cnt     <= HDR_INIT;
      r_acc         <= '0;
      r_l_hold      <= '0;
      audio_l       <= '0;
      audio_r       <= '0;
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_hdr_cnt     <= HDR_INIT;
      r_acc         <= '0;
      r_l_hold      <= '0;
      audio_l       <= '0;
      audio_r       <= '0;
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (w_hdr_drop)
        r_hdr_cnt <= r_hdr_cnt - 16'd1;
      if (w_write)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Subtracting rather than clearing keeps the remainder, so the long-term rate is exact.
      r_acc <= w_tick ? (w_acc_sum - CLK_LIM) : w_acc_sum;
      if (r_state == S_RD_R)
        r_l_hold <= r_rd_data;
      overflow      <= w_ovf;
      underflow     <= w_underflow;
      sample_strobe <= w_mute || w_present;
      if (w_mute) begin
        audio_l <= '0;
        audio_r <= '0;
      end else if (w_present) begin
        audio_l <= r_l_hold;
        audio_r <= r_rd_data;
      end
    end
  end

endmodule
